shifter: RTL and testbench
==========================

Name: shifter

Overview:
- 32-bit registered barrel shifter used as the shift unit beside the ALU in the processor datapath.
- Performs logical right, arithmetic right and logical left shifts, plus rotate right, by 0–31 bit positions.
- Result is captured in an output register one clock after the operands are presented.

Parameters:
- WIDTH, 32, data width in bits; the design is only required to work at 32.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in  input  32  operand to shift
- shiftop  input  2  operation select: 00 SRL, 01 SRA, 10 SLL, 11 ROR
- shiftamt  input  5  shift distance, 0–31, unsigned
- valid_in  input  1  operands valid this cycle
- result  output  32  registered shift result
- valid_out  output  1  result holds a newly computed value

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n=0: result=32'h0000_0000 and valid_out=0, immediately and independent of clk.
  - Deassertion is synchronised by the integrator; the block needs no internal handling for it.
- Latency and capture:
  - Exactly 1 cycle.
  - On each rising clk edge with valid_in=1: result <= f(in, shiftop, shiftamt) and valid_out <= 1.
- Idle cycles:
  - With valid_in=0 at the edge: result holds its previous value and valid_out <= 0.
- Flow control:
  - No backpressure; one operation can be accepted every cycle.
  - Back-to-back valid_in produces back-to-back valid_out.
- Operations:
  - 00 SRL: in >> shiftamt; vacated MSBs are filled with 0.
  - 01 SRA: vacated MSBs are filled with in[31] (sign extension).
  - 10 SLL: in << shiftamt; vacated LSBs are filled with 0.
  - 11 ROR: bits shifted out of bit 0 re-enter at bit 31.
- Structure:
  - Combinational core is a 5-stage log-shifter, stage k shifting by 2^k when shiftamt[k]=1.
  - Left shift may be implemented by bit-reversing input and output around the right shifter.
  - The fill bit is selected from shiftop.
- Boundary conditions:
  - shiftamt=0: result equals in for every shiftop.
  - shiftamt=31:
    - SRL gives {31'b0, in[31]}.
    - SRA gives all copies of in[31].
    - SLL gives {in[0], 31'b0}.
    - ROR gives {in[30:0], in[31]}.
  - No overflow or carry flags are produced; bits shifted out are discarded, except for ROR.
- Asynchronous reset mid-operation: an in-flight operation is lost, result=0, valid_out=0.
- No X propagation:
  - All 4 shiftop codes are defined.
  - If an X reaches an input, the result is don't-care, but valid_out must still follow valid_in.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with valid_in=1 -> result=0, valid_out=0 immediately; after release, first edge with valid_in=1 gives a correct result.
- SRL: in=32'h0000_0001, shiftop=00, shiftamt=1,2,3 -> result=0 each cycle; in=32'h8000_0000, shiftamt=3 -> 32'h1000_0000.
- SRA: in=32'h0000_0001, shiftop=01, shiftamt=1,2,3 -> result=0.
- SRA sign fill: in=32'h8000_0000, shiftop=01, shiftamt=4 -> 32'hF800_0000; shiftamt=31 -> 32'hFFFF_FFFF.
- SLL: in=32'h0000_0001, shiftop=10, shiftamt=1,2,3 -> 32'h2, 32'h4, 32'h8 on consecutive cycles with valid_out=1; shiftamt=31 -> 32'h8000_0000.
- ROR and edges: in=32'h0000_0001, shiftop=11, shiftamt=1 -> 32'h8000_0000; shiftamt=0 with each op -> result=in.
- Handshake: valid_in pattern 1,0,1 -> valid_out 1,0,1 one cycle later, and result is held during the 0 cycle.

Source files
------------

// File: rtl/shifter.sv
// 32-bit registered barrel shifter (SRL/SRA/SLL/ROR) with a one-cycle result register.
// The combinational core is a 5-stage right log-shifter; left shifts reuse it by bit reversal.
module shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in,
   input  logic [1:0]         shiftop,
   input  logic [SHAMT_W-1:0] shiftamt,
   input  logic               valid_in,
   output logic [WIDTH-1:0]   result,
   output logic               valid_out
);

   typedef enum logic [1:0] {
      OP_SRL = 2'b00,
      OP_SRA = 2'b01,
      OP_SLL = 2'b10,
      OP_ROR = 2'b11
   } shift_op_e;

   function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
      return r;
   endfunction

   shift_op_e        op;
   logic             is_left;
   logic             is_ror;
   logic             fill;
   logic [WIDTH-1:0] stage [0:SHAMT_W];
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] result_d, result_q;
   logic             valid_d, valid_q;

   assign op      = shift_op_e'(shiftop);
   assign is_left = (op == OP_SLL);
   assign is_ror  = (op == OP_ROR);
   // Only SRA fills with the sign bit; ROR wraps instead of filling.
   assign fill    = (op == OP_SRA) ? in[WIDTH-1] : 1'b0;

   assign stage[0] = is_left ? bit_reverse(in) : in;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      localparam int S = 1 << k;
      always_comb begin
         // NOTE: every path assigns stage[k+1]; a missing default here would infer a latch.
         stage[k+1] = stage[k];
         if (shiftamt[k]) begin
            if (is_ror) stage[k+1] = {stage[k][S-1:0], stage[k][WIDTH-1:S]};
            else        stage[k+1] = {{S{fill}}, stage[k][WIDTH-1:S]};
         end
      end
   end

   assign shifted  = is_left ? bit_reverse(stage[SHAMT_W]) : stage[SHAMT_W];
   assign result_d = valid_in ? shifted : result_q;
   assign valid_d  = valid_in;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!rst_n) begin
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign result    = result_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_shifter.sv
// Directed self-checking bench for shifter: hand-computed vectors, immediate assertions.
module tb_shifter;

   logic        clk;
   logic        rst_n;
   logic [31:0] in;
   logic [1:0]  shiftop;
   logic [4:0]  shiftamt;
   logic        valid_in;
   logic [31:0] result;
   logic        valid_out;

   int vectors    = 0;
   int miscompares = 0;

   localparam logic [1:0] SRL = 2'b00, SRA = 2'b01, SLL = 2'b10, ROR = 2'b11;

   shifter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in),
      .shiftop   (shiftop),
      .shiftamt  (shiftamt),
      .valid_in  (valid_in),
      .result    (result),
      .valid_out (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive operands at the falling edge, then sample 1 time unit after the capturing edge.
   task automatic step(input logic v, input logic [31:0] d, input logic [1:0] op,
                       input logic [4:0] amt);
      @(negedge clk);
      valid_in = v;
      in       = d;
      shiftop  = op;
      shiftamt = amt;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_result(input string tag, input logic [31:0] exp);
      check({tag, " result"}, result, exp);
      check({tag, " valid"}, {31'b0, valid_out}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; valid_in = 1'b1; in = 32'hFFFF_FFFF; shiftop = SRL; shiftamt = 5'd0;
      #3;
      check("reset result", result, 32'h0);
      check("reset valid", {31'b0, valid_out}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      step(1, 32'h0000_0001, SRL, 5'd1); expect_result("srl 1>>1", 32'h0);
      step(1, 32'h0000_0001, SRL, 5'd2); expect_result("srl 1>>2", 32'h0);
      step(1, 32'h0000_0001, SRL, 5'd3); expect_result("srl 1>>3", 32'h0);
      step(1, 32'h8000_0000, SRL, 5'd3); expect_result("srl msb>>3", 32'h1000_0000);
      step(1, 32'h8000_0001, SRL, 5'd31); expect_result("srl 31", 32'h0000_0001);
      step(1, 32'h8765_4321, SRL, 5'd8); expect_result("srl 8", 32'h0087_6543);

      step(1, 32'h0000_0001, SRA, 5'd1); expect_result("sra 1>>1", 32'h0);
      step(1, 32'h0000_0001, SRA, 5'd2); expect_result("sra 1>>2", 32'h0);
      step(1, 32'h0000_0001, SRA, 5'd3); expect_result("sra 1>>3", 32'h0);
      step(1, 32'h8000_0000, SRA, 5'd4); expect_result("sra fill 4", 32'hF800_0000);
      step(1, 32'h8000_0000, SRA, 5'd31); expect_result("sra fill 31", 32'hFFFF_FFFF);
      step(1, 32'h7000_0000, SRA, 5'd4); expect_result("sra pos 4", 32'h0700_0000);
      step(1, 32'h8765_4321, SRA, 5'd8); expect_result("sra 8", 32'hFF87_6543);

      step(1, 32'h0000_0001, SLL, 5'd1); expect_result("sll 1<<1", 32'h0000_0002);
      step(1, 32'h0000_0001, SLL, 5'd2); expect_result("sll 1<<2", 32'h0000_0004);
      step(1, 32'h0000_0001, SLL, 5'd3); expect_result("sll 1<<3", 32'h0000_0008);
      step(1, 32'h0000_0001, SLL, 5'd31); expect_result("sll 1<<31", 32'h8000_0000);
      step(1, 32'h8000_0001, SLL, 5'd31); expect_result("sll drop msb", 32'h8000_0000);
      step(1, 32'h1234_5678, SLL, 5'd4); expect_result("sll 4", 32'h2345_6780);

      step(1, 32'h0000_0001, ROR, 5'd1); expect_result("ror 1", 32'h8000_0000);
      step(1, 32'h8000_0001, ROR, 5'd31); expect_result("ror 31", 32'h0000_0003);
      step(1, 32'h1234_5678, ROR, 5'd8); expect_result("ror 8", 32'h7812_3456);

      step(1, 32'hA5A5_0F0F, SRL, 5'd0); expect_result("srl 0", 32'hA5A5_0F0F);
      step(1, 32'hA5A5_0F0F, SRA, 5'd0); expect_result("sra 0", 32'hA5A5_0F0F);
      step(1, 32'hA5A5_0F0F, SLL, 5'd0); expect_result("sll 0", 32'hA5A5_0F0F);
      step(1, 32'hA5A5_0F0F, ROR, 5'd0); expect_result("ror 0", 32'hA5A5_0F0F);

      // Handshake 1,0,1: result holds through the idle cycle.
      step(1, 32'hF000_0000, SRL, 5'd4); expect_result("hs first", 32'h0F00_0000);
      step(0, 32'h1234_5678, SLL, 5'd7);
      check("hs idle result", result, 32'h0F00_0000);
      check("hs idle valid", {31'b0, valid_out}, 32'd0);
      step(1, 32'h0000_000F, ROR, 5'd4); expect_result("hs third", 32'hF000_0000);

      // Reset asserted mid-cycle while an operation is presented.
      step(1, 32'h0000_0001, SLL, 5'd5); expect_result("pre reset", 32'h0000_0020);
      #1 rst_n = 1'b0;
      #1;
      check("mid reset result", result, 32'h0);
      check("mid reset valid", {31'b0, valid_out}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      step(1, 32'h8000_0000, SRA, 5'd1); expect_result("post reset", 32'hC000_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
